// File: rtl/fibonacci_checker.sv
// fibonacci_checker
//   Self-check monitor for a Fibonacci term stream. After two seed terms,
//   every term must equal the modulo-2^WIDTH sum of the two preceding terms.
//   A mismatch latches the expected and received values. ERROR can only be
//   left through clear or reset.
//
// Parameters
//   WIDTH    term width, which must match the generator output width
//   COUNT_W  width of the saturating accepted-term counter
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   fib_in      term under test
//   fib_valid   sample strobe for fib_in
//   clear       synchronous soft clear; it has priority over fib_valid
//   locked      tracking, with at least one successful check
//   error       sticky mismatch flag
//   expected    expected value of the term that failed
//   received    actual value of the term that failed
//   wrapped     sticky; some checked sum carried out of WIDTH bits
//   term_count  number of accepted terms, saturating
//
// Build option
//   FIB_CHECKER_STRICT_SEED_EN  when defined, both seed terms must be 1
module fibonacci_checker #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   fib_in,
  input  logic               fib_valid,
  input  logic               clear,
  output logic               locked,
  output logic               error,
  output logic [WIDTH-1:0]   expected,
  output logic [WIDTH-1:0]   received,
  output logic               wrapped,
  output logic [COUNT_W-1:0] term_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED1 = 2'd1,
    TRACK = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
`ifdef FIB_CHECKER_STRICT_SEED_EN
  localparam logic [WIDTH-1:0]   SEED_ONE = WIDTH'(1);
`endif

  state_t             state;
  logic [WIDTH-1:0]   prev1;
  logic [WIDTH-1:0]   prev2;
  logic [WIDTH:0]     sum;
  logic [COUNT_W-1:0] count_next;

  always_comb begin
    sum        = {1'b0, prev1} + {1'b0, prev2};
    count_next = (term_count == '1) ? term_count : term_count + CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      prev1      <= '0;
      prev2      <= '0;
      locked     <= 1'b0;
      error      <= 1'b0;
      expected   <= '0;
      received   <= '0;
      wrapped    <= 1'b0;
      term_count <= '0;
    end else if (clear) begin
      state      <= IDLE;
      prev1      <= '0;
      prev2      <= '0;
      locked     <= 1'b0;
      error      <= 1'b0;
      expected   <= '0;
      received   <= '0;
      wrapped    <= 1'b0;
      term_count <= '0;
    end else if (fib_valid) begin
      case (state)
        IDLE: begin
`ifdef FIB_CHECKER_STRICT_SEED_EN
          if (fib_in != SEED_ONE) begin
            state    <= ERROR;
            error    <= 1'b1;
            expected <= SEED_ONE;
            received <= fib_in;
          end else begin
            state      <= SEED1;
            prev1      <= fib_in;
            term_count <= count_next;
          end
`else
          state      <= SEED1;
          prev1      <= fib_in;
          term_count <= count_next;
`endif
        end
        SEED1: begin
`ifdef FIB_CHECKER_STRICT_SEED_EN
          if (fib_in != SEED_ONE) begin
            state    <= ERROR;
            error    <= 1'b1;
            expected <= SEED_ONE;
            received <= fib_in;
          end else begin
            state      <= TRACK;
            prev2      <= prev1;
            prev1      <= fib_in;
            term_count <= count_next;
          end
`else
          state      <= TRACK;
          prev2      <= prev1;
          prev1      <= fib_in;
          term_count <= count_next;
`endif
        end
        TRACK: begin
          if (fib_in == sum[WIDTH-1:0]) begin
            prev2      <= prev1;
            prev1      <= fib_in;
            term_count <= count_next;
            locked     <= 1'b1;
            if (sum[WIDTH]) wrapped <= 1'b1;
          end else begin
            state    <= ERROR;
            locked   <= 1'b0;
            error    <= 1'b1;
            expected <= sum[WIDTH-1:0];
            received <= fib_in;
          end
        end
        default: begin
          // ERROR is absorbing; valid strobes are ignored here
          state <= ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_checker.sv
module tb_fibonacci_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fib_in;
  logic        fib_valid;
  logic        clear;
  logic        locked;
  logic        error;
  logic [15:0] expected;
  logic [15:0] received;
  logic        wrapped;
  logic [7:0]  term_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fibonacci_checker #(.WIDTH(16), .COUNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .fib_in     (fib_in),
    .fib_valid  (fib_valid),
    .clear      (clear),
    .locked     (locked),
    .error      (error),
    .expected   (expected),
    .received   (received),
    .wrapped    (wrapped),
    .term_count (term_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge. Presents one term for a single cycle and
  // returns at the next falling edge, when the registered update is visible.
  task automatic send(input logic [15:0] v);
    fib_in    = v;
    fib_valid = 1'b1;
    @(negedge clk);
    fib_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"},   32'(locked),     32'd0);
    chk({tag, "_error"},    32'(error),      32'd0);
    chk({tag, "_expected"}, 32'(expected),   32'd0);
    chk({tag, "_received"}, 32'(received),   32'd0);
    chk({tag, "_wrapped"},  32'(wrapped),    32'd0);
    chk({tag, "_count"},    32'(term_count), 32'd0);
  endtask

  logic [15:0] fa, fb, fv;

  initial begin
    reset     = 1'b0;
    fib_in    = '0;
    fib_valid = 1'b0;
    clear     = 1'b0;
    idle(3);
    chk_all_zero("reset");
    reset = 1'b1;
    idle(2);

    // Nominal stream at 1-in-4 cadence
    send(16'd1); chk("seed1_locked", 32'(locked), 32'd0); idle(3);
    send(16'd1); chk("seed2_locked", 32'(locked), 32'd0); idle(3);
    send(16'd2); chk("third_locked", 32'(locked), 32'd1); idle(3);
    send(16'd3); idle(3);
    send(16'd5); idle(3);
    send(16'd8); idle(3);
    send(16'd13);
    chk("nominal_count",   32'(term_count), 32'd7);
    chk("nominal_error",   32'(error),      32'd0);
    chk("nominal_wrapped", 32'(wrapped),    32'd0);
    chk("nominal_locked",  32'(locked),     32'd1);
    idle(3);

    do_clear();
    chk_all_zero("clear1");

    // Mismatch 1,1,2,4
    send(16'd1); send(16'd1); send(16'd2); send(16'd4);
    chk("mis_error",    32'(error),      32'd1);
    chk("mis_expected", 32'(expected),   32'd3);
    chk("mis_received", 32'(received),   32'd4);
    chk("mis_locked",   32'(locked),     32'd0);
    chk("mis_count",    32'(term_count), 32'd3);
    send(16'd7);
    chk("absorb_error",    32'(error),      32'd1);
    chk("absorb_expected", 32'(expected),   32'd3);
    chk("absorb_received", 32'(received),   32'd4);
    chk("absorb_count",    32'(term_count), 32'd3);
    chk("absorb_locked",   32'(locked),     32'd0);

    // Clear together with a valid strobe discards the sample
    fib_in = 16'd9; fib_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    fib_valid = 1'b0; clear = 1'b0;
    chk_all_zero("clear_valid");
    send(16'd1);
    chk("after_clear_count", 32'(term_count), 32'd1);
    chk("after_clear_error", 32'(error),      32'd0);
    do_clear();

`ifndef FIB_CHECKER_STRICT_SEED_EN
    // Modulo wrap is legal
    send(16'd40000); send(16'd30000); send(16'd4464);
    chk("wrap_error",   32'(error),      32'd0);
    chk("wrap_wrapped", 32'(wrapped),    32'd1);
    chk("wrap_count",   32'(term_count), 32'd3);
    chk("wrap_locked",  32'(locked),     32'd1);
    send(16'd34464);
    chk("wrap2_error",   32'(error),      32'd0);
    chk("wrap2_wrapped", 32'(wrapped),    32'd1);
    chk("wrap2_count",   32'(term_count), 32'd4);
    do_clear();

    // Duplicate terms 0,0,0
    send(16'd0); send(16'd0); send(16'd0);
    chk("zeros_error",  32'(error),  32'd0);
    chk("zeros_locked", 32'(locked), 32'd1);
    do_clear();
`endif

    // Asynchronous reset mid-stream
    send(16'd1); send(16'd1); send(16'd2); send(16'd3); send(16'd5);
    chk("pre_reset_count", 32'(term_count), 32'd5);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    idle(1);
`ifndef FIB_CHECKER_STRICT_SEED_EN
    send(16'd2); send(16'd3); send(16'd5);
`else
    send(16'd1); send(16'd1); send(16'd2);
`endif
    chk("post_reset_error",  32'(error),      32'd0);
    chk("post_reset_locked", 32'(locked),     32'd1);
    chk("post_reset_count",  32'(term_count), 32'd3);
    do_clear();

    // Back-to-back stream of 260 terms: count saturates, checking continues
    fa = 16'd1; fb = 16'd1;
    fib_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      if (i < 2) fv = 16'd1;
      else begin
        fv = fa + fb;
        fb = fa;
        fa = fv;
      end
      fib_in = fv;
      @(negedge clk);
    end
    fib_valid = 1'b0;
    chk("sat_count",   32'(term_count), 32'd255);
    chk("sat_error",   32'(error),      32'd0);
    chk("sat_locked",  32'(locked),     32'd1);
    chk("sat_wrapped", 32'(wrapped),    32'd1);
    // After saturation a bad term must still be caught
    send(fa + fb + 16'd1);
    chk("sat_mis_error",    32'(error),      32'd1);
    chk("sat_mis_expected", 32'(expected),   32'(fa + fb));
    chk("sat_mis_count",    32'(term_count), 32'd255);
    do_clear();

`ifdef FIB_CHECKER_STRICT_SEED_EN
    send(16'd2);
    chk("strict_error",    32'(error),      32'd1);
    chk("strict_expected", 32'(expected),   32'd1);
    chk("strict_received", 32'(received),   32'd2);
    chk("strict_count",    32'(term_count), 32'd0);
    send(16'd3);
    chk("strict_absorb", 32'(received), 32'd2);
    do_clear();
    send(16'd1); send(16'd1); send(16'd2);
    chk("strict_ok_locked", 32'(locked), 32'd1);
    chk("strict_ok_error",  32'(error),  32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fibonacci_checker.md
# fibonacci_checker

Consumer-side companion to the team's `fibonacci` generator. It samples a stream of 16-bit terms and verifies that each term after the first two equals the modulo-2^WIDTH sum of the two preceding terms. It reports lock, a sticky error with the expected and received values, a term count, and a sticky wrap indication. It sits on the generator's output bus in lab and FPGA builds as a self-check monitor.

## Interface
- `WIDTH`, 16, term width in bits; must match the generator output width.
- `COUNT_W`, 8, width of the accepted-term counter.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous active-low reset; when 0, all state and outputs clear immediately.
- `fib_in`  input  WIDTH  term under test.
- `fib_valid`  input  1  one-cycle strobe; `fib_in` is sampled as a new term on the rising edge where this is 1.
- `clear`  input  1  synchronous soft clear; same effect as reset, taken on the clock edge.
- `locked`  output  1  high while in TRACK, meaning at least 3 consistent terms have been seen.
- `error`  output  1  sticky mismatch flag.
- `expected`  output  WIDTH  expected value of the term that failed; holds its value while `error` is 1.
- `received`  output  WIDTH  actual `fib_in` value of the term that failed.
- `wrapped`  output  1  sticky; set when any checked sum carried out of WIDTH bits.
- `term_count`  output  COUNT_W  number of accepted terms; saturates at 2^COUNT_W-1.

## Operation
- Internal registers: `prev1` (latest term), `prev2` (term before it), and the state.
- State machine:
  - IDLE → SEED1 on valid: store `prev1=fib_in`, count=1.
  - SEED1 → TRACK on valid: `prev2=prev1`, `prev1=fib_in`, count=2.
  - In TRACK on valid:
    - Compute sum = `prev1+prev2` (WIDTH+1 bits); expected = sum[WIDTH-1:0].
    - Match: shift the term into `prev1`/`prev2`, count+1, and set `wrapped` if sum[WIDTH]=1.
    - Mismatch: go to ERROR; latch `expected` and `received`; count is not incremented.
  - ERROR: absorbing state. Valid strobes are ignored. Exit only by `clear` or `reset`.
- `locked` is 1 in TRACK after the first successful check, i.e. after the 3rd accepted term. It is 0 in ERROR.
- Wrap is legal: the generator wraps silently, so a modulo-correct term is not an error.
- Duplicate terms are legal when arithmetically correct (for example 1,1 or 0,0,0).
- `clear` and `fib_valid` in the same cycle: `clear` wins and the sample is discarded.
- `term_count` saturates; it does not wrap. Checking continues after saturation.

## Timing
- All outputs are registered. An update is visible the cycle after the valid edge (latency 1).
- Reset values: `locked`=0, `error`=0, `expected`=0, `received`=0, `wrapped`=0, `term_count`=0, state=IDLE, `prev1`=`prev2`=0.
- Reset asserted mid-stream clears everything asynchronously. The first valid after reset deasserts is treated as a seed.
- `clear` takes effect on the next rising edge. Outputs return to reset values one cycle after `clear` is sampled.
- Back-to-back valids (every cycle) are supported. No minimum spacing is required, so the generator's 1-in-4 cadence is a subset.
- `error` and `locked` are never 1 simultaneously.

## Configuration
- `FIB_CHECKER_STRICT_SEED_EN`:
  - Defined: the two seed terms must both equal 1, matching the generator's reset values.
    - A seed other than 1 goes straight to ERROR.
    - `expected` latches 1 and `received` latches the bad seed.
    - `term_count` does not advance for the rejected seed.
  - Undefined: any two values are accepted as seeds, and checking starts on the 3rd term.

## Test plan
- Valid terms 1,1,2,3,5,8,13 at 1-in-4 spacing → `locked` rises the cycle after the 3rd term; final `term_count`=7, `error`=0, `wrapped`=0.
- Terms 1,1,2,4 → the cycle after the 4th term: `error`=1, `expected`=3, `received`=4, `locked`=0, `term_count`=3. A further valid 7 leaves all outputs unchanged.
- Macro undefined; seeds 40000,30000 then 4464 → no error, `wrapped`=1, `term_count`=3. A further 34464 is accepted and `wrapped` stays 1.
- Error state, then `clear` asserted together with valid 9 → `term_count`=0, `error`=0, state IDLE. The next valid 1 gives `term_count`=1.
- Reset pulsed low after 5 good terms → all outputs 0 during reset. The terms 2,3,5 that follow are accepted with the macro undefined.
- Macro defined; seeds 2,3 → `error`=1, `expected`=1, `received`=2 one cycle after the first valid. Seeds 1,1,2 → `locked`=1, no error.
